uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_counter.sv | 44 ++++
 rtl/uart_transmitter.sv | 160 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the FSM state encoding, line levels, the default payload width and
// helpers for counter sizing and frame length.
// Optional feature macro: UART_TX_PARITY_EN (adds one even-parity bit per frame).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Bits needed for a counter that takes num_values distinct values, at least 1.
  function automatic int unsigned cnt_width(input int unsigned num_values);
    return (num_values > 1) ? $clog2(num_values) : 1;
  endfunction

  // Total clk cycles from start bit to the end of the last stop bit.
  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned clks_per_bit,
                                            input int unsigned stop_bits);
    return (1 + data_width + PARITY_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while run is high and wraps on bit_tick_c.
// Ports:
//   clk        - system clock
//   clear      - synchronous clear (reset or frame start)
//   run        - count enable (frame in progress)
//   bit_tick_c - high on the last cycle of the current bit time
//   pre_tick_c - high on the cycle before the last cycle of a bit time
//                (only meaningful when CLKS_PER_BIT > 1)
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic bit_tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick_c = (count == LAST);

  // Lookahead used to register the done pulse onto the final cycle.
  if (CLKS_PER_BIT > 1) begin : g_pre
    assign pre_tick_c = (count == CNT_W'(CLKS_PER_BIT - 2));
  end else begin : g_no_pre
    assign pre_tick_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= bit_tick_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART serial transmitter.
// Frame: start bit (0), DATA_WIDTH data bits LSB-first, optional even parity,
// STOP_BITS stop bits (1). Each line bit is held CLKS_PER_BIT cycles.
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit before stop bits).
// Ports:
//   clk         - system clock, rising edge
//   tx_enable_n - synchronous active-low reset
//   tx_valid    - upstream word available on tx_data
//   tx_data     - word to send, latched on handshake
//   tx_ready    - can accept a word (IDLE only)
//   tx_out      - serial line, idles high
//   tx_busy     - frame in progress
//   tx_done     - one-cycle pulse on the final cycle of the last stop bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  tx_enable_n,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BIT_W = cnt_width(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic ONE_CLK = (CLKS_PER_BIT == 1);
  // With one clk per bit and a single stop bit, the stop bit is itself the final cycle.
  localparam logic DONE_ON_STOP_ENTRY = (STOP_BITS == 1) && ONE_CLK;

  uart_state_e           state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]      bit_cnt;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  logic handshake_c;
  logic bit_tick_c;
  logic pre_tick_c;

  assign handshake_c = tx_valid && tx_ready;

  // Bit timing; restarted on reset and on every accepted word.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .clear     (!tx_enable_n || handshake_c),
    .run       (tx_busy),
    .bit_tick_c(bit_tick_c),
    .pre_tick_c(pre_tick_c)
  );

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (!tx_enable_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      tx_out   <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= IDLE_LEVEL;
          if (handshake_c) begin
            state    <= START;
            shift_q  <= tx_data;
            bit_cnt  <= '0;
            tx_out   <= START_LEVEL;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_data;
`endif
          end
        end

        START: begin
          if (bit_tick_c) begin
            state   <= DATA;
            tx_out  <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (bit_tick_c) begin
            if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_out  <= parity_q;
`else
              state   <= STOP;
              tx_out  <= IDLE_LEVEL;
              bit_cnt <= '0;
              tx_done <= DONE_ON_STOP_ENTRY;
`endif
            end else begin
              tx_out  <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick_c) begin
            state   <= STOP;
            tx_out  <= IDLE_LEVEL;
            bit_cnt <= '0;
            tx_done <= DONE_ON_STOP_ENTRY;
          end
        end
`endif

        STOP: begin
          tx_out <= IDLE_LEVEL;
          if (bit_tick_c) begin
            if (bit_cnt == LAST_STOP) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx_done <= ONE_CLK && ((bit_cnt + BIT_W'(1)) == LAST_STOP);
            end
          end else begin
            // Raise done so it lands on the wrap cycle of the last stop bit.
            tx_done <= (bit_cnt == LAST_STOP) && pre_tick_c;
          end
        end

        default: begin
          state    <= IDLE;
          tx_out   <= IDLE_LEVEL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: three instances cover the default
// timing, a 4-clk bit time and two stop bits. Expected line/done values are
// queued per cycle at each handshake and checked on the falling edge.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int          N_DUT = 3;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    bit line;
    bit done;
  } exp_t;

  logic          clk = 1'b0;
  logic          en_n;
  logic          valid [N_DUT];
  logic [DW-1:0] data  [N_DUT];
  logic          ready [N_DUT];
  logic          line  [N_DUT];
  logic          busy  [N_DUT];
  logic          done  [N_DUT];

  exp_t exp_q[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   act    = 0;
  bit   mon_on = 1'b0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .tx_enable_n(en_n), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_transmitter #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .tx_enable_n(en_n), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_transmitter #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .tx_enable_n(en_n), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(ready[2]), .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );

  function automatic int unsigned cpb_of(input int idx);
    return (idx == 1) ? 4 : 1;
  endfunction

  function automatic int unsigned sb_of(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Queue the expected line level and done flag for every cycle of one frame.
  task automatic push_frame(input int idx, input logic [DW-1:0] w);
    bit   bits[$];
    exp_t e;
    int   nb;
    int   c;
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(w[i]);
    if (PAR_EN) bits.push_back(^w);
    for (int i = 0; i < int'(sb_of(idx)); i++) bits.push_back(1'b1);
    nb = bits.size();
    c  = int'(cpb_of(idx));
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < c; k++) begin
        e.line = bits[b];
        e.done = (b == nb - 1) && (k == c - 1);
        exp_q.push_back(e);
      end
    end
    cyc = 0;
  endtask

  // Offer a word, wait (bounded) for tx_ready, push expectations on the handshake edge.
  task automatic send(input int idx, input logic [DW-1:0] w, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    valid[idx] = 1'b1;
    data[idx]  = w;
    while (ready[idx] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("hs_ready", 32'(ready[idx]), 32'(1));
    if (ready[idx] !== 1'b1) begin
      valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    push_frame(idx, w);
    @(negedge clk);
    valid[idx] = 1'b0;
    data[idx]  = DW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  // Line monitor for the active instance: frame cycles from the queue, idle otherwise.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        cyc++;
        check("tx_out", 32'(line[act]), 32'(mon_e.line));
        check("tx_done", 32'(done[act]), 32'(mon_e.done));
        check("busy_frame", 32'(busy[act]), 32'(1));
        check("ready_frame", 32'(ready[act]), 32'(0));
        if (done[act] === 1'b1)
          check("frame_len", 32'(cyc), 32'(frame_len(DW, cpb_of(act), sb_of(act))));
      end else begin
        check("idle_out", 32'(line[act]), 32'(IDLE_LEVEL));
        check("idle_done", 32'(done[act]), 32'(0));
        check("idle_busy", 32'(busy[act]), 32'(0));
        check("idle_ready", 32'(ready[act]), 32'(1));
      end
    end
  end

  initial begin
    en_n = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check("rst_out", 32'(line[i]), 32'(1));
      check("rst_ready", 32'(ready[i]), 32'(1));
      check("rst_busy", 32'(busy[i]), 32'(0));
      check("rst_done", 32'(done[i]), 32'(0));
    end
    en_n   = 1'b1;
    act    = 0;
    mon_on = 1'b1;

    send(0, 8'hA5, 20);
    drain();

    for (int n = 0; n < 4; n++) send(0, DW'($urandom), 40);
    drain();

    send(0, 8'h5A, 20);
    send(0, 8'h3C, 60);
    drain();

    act = 1;
    send(1, 8'h01, 20);
    drain();

    act = 2;
    send(2, 8'h80, 20);
    drain();

    act = 0;
    send(0, 8'hFF, 20);
    repeat (4) @(negedge clk);
    #1;
    en_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    en_n = 1'b1;
    drain();

    send(0, 8'h96, 20);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
